// File: rtl/reg_file_param.sv
// reg_file_param: parametrised CPU register file for the synth core.
//   - reg 0 reads as zero, three combinational read ports, one CPU write port
//   - masked peripheral (I2C) write port with ready/valid and a one-entry
//     collision buffer that replays the masked merge after a CPU write wins
//   - PWM-mapped registers are exported only through shadow copies loaded on
//     pwm_sync, so duty values change only at a period boundary
// Optional feature: define RF_BYPASS_EN to forward same-cycle CPU write data
// to matching read ports (CPU port only).
module reg_file_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int PWM_BASE = 8,
   parameter int PWM_CH   = 8,
   parameter int I2C_CTRL = 6,
   parameter int I2C_DATA = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     write_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [ADDR_W-1:0]        rd_addr_a,
   input  logic [ADDR_W-1:0]        rd_addr_b,
   input  logic [ADDR_W-1:0]        rd_addr_c,
   output logic [DATA_W-1:0]        rd_data_a,
   output logic [DATA_W-1:0]        rd_data_b,
   output logic [DATA_W-1:0]        rd_data_c,
   input  logic                     p_wr_valid,
   output logic                     p_wr_ready,
   input  logic [ADDR_W-1:0]        p_wr_addr,
   input  logic [DATA_W-1:0]        p_wr_data,
   input  logic [DATA_W-1:0]        p_wr_mask,
   input  logic                     pwm_sync,
   output logic [PWM_CH*DATA_W-1:0] pwm_regs,
   output logic [PWM_CH-1:0]        pwm_update,
   output logic [DATA_W-1:0]        i2c_ctrl,
   output logic [DATA_W-1:0]        i2c_data
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs [NUM_REGS];

   // one-entry buffer holding a peripheral write that lost to the CPU
   logic              pend_valid_reg;
   logic [ADDR_W-1:0] pend_addr_reg;
   logic [DATA_W-1:0] pend_data_reg;
   logic [DATA_W-1:0] pend_mask_reg;

   logic p_accept;
   logic collision;

   // the port stalls only while a replay is outstanding
   assign p_wr_ready = ~pend_valid_reg;
   assign p_accept   = p_wr_valid & ~pend_valid_reg;
   assign collision  = p_accept & write_en & (wr_addr == p_wr_addr) & (p_wr_addr != '0);

   // register array update: CPU write wins, then live peripheral write or replay
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (write_en && wr_addr == ADDR_W'(i)) begin
               regs[i] <= wr_data;
            end else if (p_accept && p_wr_addr == ADDR_W'(i)) begin
               regs[i] <= (regs[i] & ~p_wr_mask) | (p_wr_data & p_wr_mask);
            end else if (pend_valid_reg && pend_addr_reg == ADDR_W'(i)) begin
               regs[i] <= (regs[i] & ~pend_mask_reg) | (pend_data_reg & pend_mask_reg);
            end
         end
      end
   end

   // capture on collision; clear once the replay merge lands without a CPU hit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid_reg <= 1'b0;
         pend_addr_reg  <= '0;
         pend_data_reg  <= '0;
         pend_mask_reg  <= '0;
      end else if (pend_valid_reg) begin
         if (!(write_en && wr_addr == pend_addr_reg)) begin
            pend_valid_reg <= 1'b0;
         end
      end else if (collision) begin
         pend_valid_reg <= 1'b1;
         pend_addr_reg  <= p_wr_addr;
         pend_data_reg  <= p_wr_data;
         pend_mask_reg  <= p_wr_mask;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(
      input logic [ADDR_W-1:0] addr,
      input logic              we,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata
   );
      logic [DATA_W-1:0] value;
      value = (addr == '0) ? '0 : regs[addr];
`ifdef RF_BYPASS_EN
      if (we && addr == waddr && waddr != '0) begin
         value = wdata;
      end
`else
      if (we && addr == waddr && wdata == '0) begin
         value = regs[addr];
      end
`endif
      return value;
   endfunction

   assign rd_data_a = read_port(rd_addr_a, write_en, wr_addr, wr_data);
   assign rd_data_b = read_port(rd_addr_b, write_en, wr_addr, wr_data);
   assign rd_data_c = read_port(rd_addr_c, write_en, wr_addr, wr_data);

   assign i2c_ctrl = regs[I2C_CTRL];
   assign i2c_data = regs[I2C_DATA];

   for (genvar gi = 0; gi < PWM_CH; gi++) begin : g_pwm
      logic [DATA_W-1:0] shadow_reg;
      logic              update_reg;

      // load shadow from pre-edge register value on sync; flag a changed duty
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            shadow_reg <= '0;
            update_reg <= 1'b0;
         end else begin
            update_reg <= pwm_sync && (regs[PWM_BASE+gi] != shadow_reg);
            if (pwm_sync) begin
               shadow_reg <= regs[PWM_BASE+gi];
            end
         end
      end

      assign pwm_regs[gi*DATA_W +: DATA_W] = shadow_reg;
      assign pwm_update[gi]                = update_reg;
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised self-checking bench for reg_file_param with a register-level
// reference model; directed scenarios cover reset, masking, collision replay,
// PWM shadow loading, read forwarding and mid-operation reset.
module tb_reg_file_param;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int NR = 16;
   localparam int PB = 8;
   localparam int PC = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          write_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0, rd_addr_c = '0;
   logic [DW-1:0] rd_data_a, rd_data_b, rd_data_c;
   logic          p_wr_valid = 1'b0;
   logic          p_wr_ready;
   logic [AW-1:0] p_wr_addr = '0;
   logic [DW-1:0] p_wr_data = '0;
   logic [DW-1:0] p_wr_mask = '0;
   logic          pwm_sync = 1'b0;
   logic [PC*DW-1:0] pwm_regs;
   logic [PC-1:0]    pwm_update;
   logic [DW-1:0]    i2c_ctrl, i2c_data;

   int tests_run = 0;
   int tests_failed = 0;

   // reference model state
   logic [DW-1:0] m_regs [NR];
   logic [DW-1:0] m_sh   [PC];
   logic [PC-1:0] m_upd;
   logic          m_pend;
   logic [AW-1:0] m_pa;
   logic [DW-1:0] m_pd, m_pm;

   reg_file_param dut (
      .clk(clk), .rst(rst),
      .write_en(write_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c),
      .p_wr_valid(p_wr_valid), .p_wr_ready(p_wr_ready),
      .p_wr_addr(p_wr_addr), .p_wr_data(p_wr_data), .p_wr_mask(p_wr_mask),
      .pwm_sync(pwm_sync), .pwm_regs(pwm_regs), .pwm_update(pwm_update),
      .i2c_ctrl(i2c_ctrl), .i2c_data(i2c_data)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      for (int k = 0; k < PC; k++) m_sh[k] = '0;
      m_upd = '0; m_pend = 1'b0; m_pa = '0; m_pd = '0; m_pm = '0;
   endtask

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
`ifdef RF_BYPASS_EN
      if (write_en && a == wr_addr) return wr_data;
`endif
      return m_regs[a];
   endfunction

   function automatic logic [PC*DW-1:0] exp_pwm();
      logic [PC*DW-1:0] v;
      for (int k = 0; k < PC; k++) v[k*DW +: DW] = m_sh[k];
      return v;
   endfunction

   // advance one clock: apply current inputs to the model and the DUT, end at negedge
   task automatic tick();
      logic [DW-1:0] nr [NR];
      logic [DW-1:0] nsh [PC];
      logic [PC-1:0] nupd;
      logic          np;
      logic [AW-1:0] npa;
      logic [DW-1:0] npd, npm;
      nr = m_regs; nsh = m_sh; np = m_pend; npa = m_pa; npd = m_pd; npm = m_pm;
      if (write_en && wr_addr != 0) nr[wr_addr] = wr_data;
      if (m_pend) begin
         if (!(write_en && wr_addr == m_pa)) begin
            nr[m_pa] = (m_regs[m_pa] & ~m_pm) | (m_pd & m_pm);
            np = 1'b0;
         end
      end else if (p_wr_valid && p_wr_addr != 0) begin
         if (write_en && wr_addr == p_wr_addr) begin
            np = 1'b1; npa = p_wr_addr; npd = p_wr_data; npm = p_wr_mask;
         end else begin
            nr[p_wr_addr] = (m_regs[p_wr_addr] & ~p_wr_mask) | (p_wr_data & p_wr_mask);
         end
      end
      for (int k = 0; k < PC; k++) begin
         nupd[k] = pwm_sync && (m_regs[PB+k] != m_sh[k]);
         if (pwm_sync) nsh[k] = m_regs[PB+k];
      end
      @(posedge clk);
      m_regs = nr; m_sh = nsh; m_upd = nupd;
      m_pend = np; m_pa = npa; m_pd = npd; m_pm = npm;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      write_en = 1'b0; p_wr_valid = 1'b0; pwm_sync = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < NR; i++) begin
         rd_addr_a = AW'(i);
         #1;
         tests_run++;
         if (rd_data_a !== '0) begin
            tests_failed++;
            $display("FAIL reset_read addr %0d: got %h expected 0000", i, rd_data_a);
         end
      end
      tests_run++;
      if (p_wr_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b expected 1", p_wr_ready);
      end
      tests_run++;
      if (pwm_regs !== '0 || pwm_update !== '0) begin
         tests_failed++;
         $display("FAIL reset_pwm: got regs %h upd %b expected 0", pwm_regs, pwm_update);
      end
   endtask

   task automatic test_cpu_write();
      write_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
      tick();
      write_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234;
      tick();
      idle_inputs();
      rd_addr_a = 4'd3; rd_addr_c = 4'd0;
      #1;
      tests_run++;
      if (rd_data_a !== 16'hBEEF) begin
         tests_failed++;
         $display("FAIL cpu_write_reg3: got %h expected beef", rd_data_a);
      end
      tests_run++;
      if (rd_data_c !== 16'h0000) begin
         tests_failed++;
         $display("FAIL cpu_write_reg0: got %h expected 0000", rd_data_c);
      end
   endtask

   task automatic test_masked_write();
      write_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h00FF;
      tick();
      write_en = 1'b0;
      p_wr_valid = 1'b1; p_wr_addr = 4'd6; p_wr_data = 16'h0300; p_wr_mask = 16'h0300;
      tick();
      idle_inputs();
      rd_addr_a = 4'd6;
      #1;
      tests_run++;
      if (rd_data_a !== 16'h03FF || i2c_ctrl !== 16'h03FF) begin
         tests_failed++;
         $display("FAIL masked_write: got rd %h i2c_ctrl %h expected 03ff", rd_data_a, i2c_ctrl);
      end
      tests_run++;
      if (p_wr_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL masked_ready: got %b expected 1", p_wr_ready);
      end
   endtask

   task automatic test_collision();
      write_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1111;
      p_wr_valid = 1'b1; p_wr_addr = 4'd7; p_wr_data = 16'hAB00; p_wr_mask = 16'hFF00;
      tick();
      idle_inputs();
      rd_addr_b = 4'd7;
      #1;
      tests_run++;
      if (rd_data_b !== 16'h1111 || p_wr_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL collision_capture: got rd %h ready %b expected 1111 ready 0", rd_data_b, p_wr_ready);
      end
      tick();
      tests_run++;
      if (rd_data_b !== 16'hAB11 || i2c_data !== 16'hAB11) begin
         tests_failed++;
         $display("FAIL collision_replay: got rd %h i2c_data %h expected ab11", rd_data_b, i2c_data);
      end
      tests_run++;
      if (p_wr_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL collision_ready: got %b expected 1", p_wr_ready);
      end
   endtask

   task automatic test_pwm();
      write_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0400;
      tick();
      idle_inputs();
      #1;
      tests_run++;
      if (pwm_regs[1*DW +: DW] !== 16'h0000) begin
         tests_failed++;
         $display("FAIL pwm_hold: got ch1 %h expected 0000", pwm_regs[1*DW +: DW]);
      end
      pwm_sync = 1'b1;
      tick();
      pwm_sync = 1'b0;
      tests_run++;
      if (pwm_regs[1*DW +: DW] !== 16'h0400) begin
         tests_failed++;
         $display("FAIL pwm_load: got ch1 %h expected 0400", pwm_regs[1*DW +: DW]);
      end
      tests_run++;
      if (pwm_update !== 8'b0000_0010) begin
         tests_failed++;
         $display("FAIL pwm_update_pulse: got %b expected 00000010", pwm_update);
      end
      tick();
      tests_run++;
      if (pwm_update !== 8'b0000_0000) begin
         tests_failed++;
         $display("FAIL pwm_update_clear: got %b expected 00000000", pwm_update);
      end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] want;
`ifdef RF_BYPASS_EN
      want = 16'h55AA;
`else
      want = 16'h0000;
`endif
      write_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h55AA; rd_addr_b = 4'd2;
      #1;
      tests_run++;
      if (rd_data_b !== want) begin
         tests_failed++;
         $display("FAIL bypass_read: got %h expected %h", rd_data_b, want);
      end
      tick();
      idle_inputs();
      #1;
      tests_run++;
      if (rd_data_b !== 16'h55AA) begin
         tests_failed++;
         $display("FAIL bypass_after: got %h expected 55aa", rd_data_b);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         write_en   = ($urandom_range(0, 1) == 1);
         wr_addr    = AW'($urandom_range(0, NR-1));
         wr_data    = DW'($urandom);
         p_wr_valid = ($urandom_range(0, 1) == 1);
         p_wr_addr  = ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom_range(0, NR-1));
         p_wr_data  = DW'($urandom);
         p_wr_mask  = DW'($urandom);
         pwm_sync   = ($urandom_range(0, 3) == 0);
         rd_addr_a  = AW'($urandom_range(0, NR-1));
         rd_addr_b  = wr_addr;
         rd_addr_c  = AW'($urandom_range(0, NR-1));
         #1;
         tests_run++;
         if (rd_data_a !== exp_rd(rd_addr_a) || rd_data_b !== exp_rd(rd_addr_b) ||
             rd_data_c !== exp_rd(rd_addr_c)) begin
            tests_failed++;
            $display("FAIL rand_read cyc %0d: got %h %h %h expected %h %h %h", n,
                     rd_data_a, rd_data_b, rd_data_c,
                     exp_rd(rd_addr_a), exp_rd(rd_addr_b), exp_rd(rd_addr_c));
         end
         tests_run++;
         if (p_wr_ready !== !m_pend) begin
            tests_failed++;
            $display("FAIL rand_ready cyc %0d: got %b expected %b", n, p_wr_ready, !m_pend);
         end
         tests_run++;
         if (pwm_regs !== exp_pwm() || pwm_update !== m_upd) begin
            tests_failed++;
            $display("FAIL rand_pwm cyc %0d: got %h/%b expected %h/%b", n,
                     pwm_regs, pwm_update, exp_pwm(), m_upd);
         end
         tests_run++;
         if (i2c_ctrl !== m_regs[6] || i2c_data !== m_regs[7]) begin
            tests_failed++;
            $display("FAIL rand_i2c cyc %0d: got %h %h expected %h %h", n,
                     i2c_ctrl, i2c_data, m_regs[6], m_regs[7]);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      // fill a PWM shadow, then leave a replay pending before resetting
      write_en = 1'b1; wr_addr = 4'd8; wr_data = 16'h00C3;
      tick();
      write_en = 1'b0; pwm_sync = 1'b1;
      tick();
      write_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h2222;
      p_wr_valid = 1'b1; p_wr_addr = 4'd5; p_wr_data = 16'hFFFF; p_wr_mask = 16'h00FF;
      pwm_sync = 1'b0;
      tick();
      idle_inputs();
      rd_addr_a = 4'd5;
      #1;
      tests_run++;
      if (p_wr_ready !== 1'b0 || pwm_regs[0 +: DW] !== 16'h00C3) begin
         tests_failed++;
         $display("FAIL mid_setup: got ready %b ch0 %h expected ready 0 ch0 00c3",
                  p_wr_ready, pwm_regs[0 +: DW]);
      end
      #1 rst = 1'b1;
      #1;
      model_reset();
      tests_run++;
      if (rd_data_a !== '0 || p_wr_ready !== 1'b1 || pwm_regs !== '0 || pwm_update !== '0) begin
         tests_failed++;
         $display("FAIL mid_reset: got rd %h ready %b pwm %h upd %b expected all clear",
                  rd_data_a, p_wr_ready, pwm_regs, pwm_update);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      tests_run++;
      if (rd_data_a !== '0 || p_wr_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_no_replay: got rd %h ready %b expected 0000 ready 1",
                  rd_data_a, p_wr_ready);
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_cpu_write();
      test_masked_write();
      test_collision();
      test_pwm();
      test_bypass();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
